// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the PC sequencer.
//   PC_W            - fetch address width
//   RESET_PC_DEF    - default PC loaded on reset
//   EXC_VECTOR_DEF  - default trap target for misaligned redirects
//   seq_state_e     - RUN / HOLD sequencer states
package pc_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [PC_W-1:0] EXC_VECTOR_DEF = 32'h8000_0180;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } seq_state_e;
endpackage

// File: rtl/branch_target_adder.sv
// branch_target_adder: combinational W-bit adder, result wraps mod 2^W.
//   a, b : operands
//   sum  : a + b, truncated, no carry out
module branch_target_adder
  import pc_pkg::*;
#(
  parameter int W = PC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register with branch/jump redirect and stall
// deferral. A redirect seen while stalled is parked in a pending register
// (HOLD state) and applied one cycle after Stall drops; later redirects
// during HOLD are wrong-path and dropped.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN. When defined, a selected
// target with non-zero bits [1:0] is replaced by EXC_VECTOR (checked at
// capture time for deferred redirects) and MisalignExc pulses alongside
// Redirected. When undefined, targets load unchecked and MisalignExc is absent.
//
// Ports:
//   Clk, Rst (sync, active high)
//   Stall                       - hold PC
//   BranchTaken, BranchOffset, BranchBasePC - branch redirect, target = base + offset
//   Jump, JumpTarget            - jump redirect (branch wins if both)
//   PC, PCPlus4                 - current fetch address and PC+4
//   Redirected                  - one-cycle flush pulse, high while PC shows new target
//   PendingRedirect             - high while in HOLD
//   MisalignExc                 - trap pulse (only with PC_MISALIGN_TRAP_EN)
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            BranchTaken,
  input  logic [PC_W-1:0] BranchOffset,
  input  logic [PC_W-1:0] BranchBasePC,
  input  logic            Jump,
  input  logic [PC_W-1:0] JumpTarget,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PCPlus4,
  output logic            Redirected,
  output logic            PendingRedirect
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic            MisalignExc
`endif
);
  seq_state_e      state_q, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [PC_W-1:0] pend_q, pend_nxt;
  logic            redir_q, redir_nxt;
  logic [PC_W-1:0] br_tgt, pc_plus4, sel_tgt, ld_tgt;
  logic            redirect;

  branch_target_adder #(.W(PC_W)) u_br_add (
    .a   (BranchBasePC),
    .b   (BranchOffset),
    .sum (br_tgt)
  );

  branch_target_adder #(.W(PC_W)) u_pc4_add (
    .a   (pc_q),
    .b   (32'd4),
    .sum (pc_plus4)
  );

  assign redirect = BranchTaken | Jump;
  assign sel_tgt  = BranchTaken ? br_tgt : JumpTarget;

`ifdef PC_MISALIGN_TRAP_EN
  logic ld_mis;
  logic exc_q, exc_nxt;
  logic pend_mis_q, pend_mis_nxt;
  assign ld_mis = |sel_tgt[1:0];
  assign ld_tgt = ld_mis ? EXC_VECTOR : sel_tgt;
`else
  assign ld_tgt = sel_tgt;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      redir_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      exc_q      <= 1'b0;
      pend_mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      pend_q  <= pend_nxt;
      redir_q <= redir_nxt;
`ifdef PC_MISALIGN_TRAP_EN
      exc_q      <= exc_nxt;
      pend_mis_q <= pend_mis_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    pend_nxt  = pend_q;
    redir_nxt = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    exc_nxt      = 1'b0;
    pend_mis_nxt = pend_mis_q;
`endif
    case (state_q)
      RUN: begin
        if (redirect) begin
          if (Stall) begin
            // park the (already checked) target until the stall clears
            pend_nxt  = ld_tgt;
            state_nxt = HOLD;
`ifdef PC_MISALIGN_TRAP_EN
            pend_mis_nxt = ld_mis;
`endif
          end else begin
            pc_nxt    = ld_tgt;
            redir_nxt = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            exc_nxt = ld_mis;
`endif
          end
        end else if (!Stall) begin
          pc_nxt = pc_plus4;
        end
      end
      HOLD: begin
        // new redirect requests here are wrong-path: ignored
        if (!Stall) begin
          pc_nxt    = pend_q;
          redir_nxt = 1'b1;
          state_nxt = RUN;
`ifdef PC_MISALIGN_TRAP_EN
          exc_nxt = pend_mis_q;
`endif
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign PC              = pc_q;
  assign PCPlus4         = pc_plus4;
  assign Redirected      = redir_q;
  assign PendingRedirect = (state_q == HOLD);
`ifdef PC_MISALIGN_TRAP_EN
  assign MisalignExc = exc_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (default parameters).
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, stall, br, jmp;
  logic [31:0] br_off, br_base, jmp_tgt;
  logic [31:0] pc, pc4;
  logic        redir, pend;
`ifdef PC_MISALIGN_TRAP_EN
  logic        mexc;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .Clk             (clk),
    .Rst             (rst),
    .Stall           (stall),
    .BranchTaken     (br),
    .BranchOffset    (br_off),
    .BranchBasePC    (br_base),
    .Jump            (jmp),
    .JumpTarget      (jmp_tgt),
    .PC              (pc),
    .PCPlus4         (pc4),
    .Redirected      (redir),
    .PendingRedirect (pend)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .MisalignExc     (mexc)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // unstalled jump used to place the PC at a known address
  task automatic goto(input logic [31:0] a);
    jmp = 1'b1; jmp_tgt = a;
    step();
    jmp = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; br = 1'b0; jmp = 1'b0;
    br_off = '0; br_base = '0; jmp_tgt = '0;
    step(); step();
    total++; if (pc !== 32'h0 || redir !== 1'b0 || pend !== 1'b0) begin
      bad++; $display("FAIL reset pc=%h redir=%b pend=%b want 0/0/0", pc, redir, pend); end
    total++; if (pc4 !== 32'h4) begin
      bad++; $display("FAIL reset_pc4 got=%h want=00000004", pc4); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (pc !== 32'(i * 4) || redir !== 1'b0) begin
        bad++; $display("FAIL seq%0d pc=%h redir=%b want %h/0", i, pc, redir, 32'(i * 4)); end
    end
  endtask

  task automatic test_branch;
    goto(32'h40);
    total++; if (pc !== 32'h40 || redir !== 1'b1) begin
      bad++; $display("FAIL jump pc=%h redir=%b want 00000040/1", pc, redir); end
    br = 1'b1; br_base = 32'h44; br_off = 32'hFFFF_FFF0;
    step();
    br = 1'b0;
    total++; if (pc !== 32'h34 || redir !== 1'b1) begin
      bad++; $display("FAIL branch pc=%h redir=%b want 00000034/1", pc, redir); end
    step();
    total++; if (pc !== 32'h38 || redir !== 1'b0) begin
      bad++; $display("FAIL branch_after pc=%h redir=%b want 00000038/0", pc, redir); end
  endtask

  task automatic test_both;
    br = 1'b1; br_base = 32'h300; br_off = 32'h20;
    jmp = 1'b1; jmp_tgt = 32'h500;
    step();
    br = 1'b0; jmp = 1'b0;
    total++; if (pc !== 32'h320) begin
      bad++; $display("FAIL both_prio got=%h want=00000320", pc); end
  endtask

  task automatic test_deferred;
    goto(32'h80);
    stall = 1'b1; jmp = 1'b1; jmp_tgt = 32'h100;
    step();
    jmp = 1'b0;
    total++; if (pc !== 32'h80 || pend !== 1'b1 || redir !== 1'b0) begin
      bad++; $display("FAIL defer1 pc=%h pend=%b redir=%b want 00000080/1/0", pc, pend, redir); end
    step();
    total++; if (pc !== 32'h80 || pend !== 1'b1) begin
      bad++; $display("FAIL defer2 pc=%h pend=%b want 00000080/1", pc, pend); end
    stall = 1'b0;
    total++; if (pc !== 32'h80 || pend !== 1'b1) begin
      bad++; $display("FAIL defer3 pc=%h pend=%b want 00000080/1", pc, pend); end
    step();
    total++; if (pc !== 32'h100 || redir !== 1'b1 || pend !== 1'b0) begin
      bad++; $display("FAIL defer_rel pc=%h redir=%b pend=%b want 00000100/1/0", pc, redir, pend); end
    step();
    total++; if (pc !== 32'h104 || redir !== 1'b0) begin
      bad++; $display("FAIL defer_after pc=%h redir=%b want 00000104/0", pc, redir); end
  endtask

  task automatic test_hold_ignore;
    goto(32'h80);
    stall = 1'b1; jmp = 1'b1; jmp_tgt = 32'h100;
    step();
    jmp = 1'b0; br = 1'b1; br_base = 32'h1F0; br_off = 32'h10;
    step();
    br = 1'b0; stall = 1'b0;
    step();
    total++; if (pc !== 32'h100 || redir !== 1'b1) begin
      bad++; $display("FAIL hold_ignore pc=%h redir=%b want 00000100/1", pc, redir); end
  endtask

  task automatic test_wrap;
    goto(32'hFFFF_FFFC);
    total++; if (pc4 !== 32'h0) begin
      bad++; $display("FAIL wrap_pc4 got=%h want=00000000", pc4); end
    step();
    total++; if (pc !== 32'h0 || redir !== 1'b0) begin
      bad++; $display("FAIL wrap pc=%h redir=%b want 00000000/0", pc, redir); end
  endtask

  task automatic test_reset_in_hold;
    goto(32'h80);
    stall = 1'b1; jmp = 1'b1; jmp_tgt = 32'h100;
    step();
    jmp = 1'b0;
    total++; if (pend !== 1'b1) begin
      bad++; $display("FAIL rst_hold_pre pend=%b want 1", pend); end
    rst = 1'b1;
    step();
    total++; if (pc !== 32'h0 || pend !== 1'b0 || redir !== 1'b0) begin
      bad++; $display("FAIL rst_hold pc=%h pend=%b redir=%b want 0/0/0", pc, pend, redir); end
    rst = 1'b0; stall = 1'b0;
    step();
    total++; if (pc !== 32'h4 || redir !== 1'b0) begin
      bad++; $display("FAIL rst_discard pc=%h redir=%b want 00000004/0", pc, redir); end
  endtask

`ifdef PC_MISALIGN_TRAP_EN
  task automatic test_misalign;
    goto(32'h102);
    total++; if (pc !== 32'h8000_0180 || redir !== 1'b1 || mexc !== 1'b1) begin
      bad++; $display("FAIL misalign pc=%h redir=%b exc=%b want 80000180/1/1", pc, redir, mexc); end
    step();
    total++; if (pc !== 32'h8000_0184 || redir !== 1'b0 || mexc !== 1'b0) begin
      bad++; $display("FAIL misalign_after pc=%h redir=%b exc=%b want 80000184/0/0", pc, redir, mexc); end
    stall = 1'b1; jmp = 1'b1; jmp_tgt = 32'h203;
    step();
    jmp = 1'b0; stall = 1'b0;
    step();
    total++; if (pc !== 32'h8000_0180 || mexc !== 1'b1) begin
      bad++; $display("FAIL misalign_defer pc=%h exc=%b want 80000180/1", pc, mexc); end
  endtask
`else
  task automatic test_unchecked;
    goto(32'h102);
    total++; if (pc !== 32'h102 || redir !== 1'b1) begin
      bad++; $display("FAIL unchecked pc=%h redir=%b want 00000102/1", pc, redir); end
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_both();
    test_deferred();
    test_hold_ignore();
    test_wrap();
    test_reset_in_hold();
`ifdef PC_MISALIGN_TRAP_EN
    test_misalign();
`else
    test_unchecked();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
